// File: rtl/dcache_sram_assoc.sv
// rtl/dcache_sram_assoc.sv - N-way set-associative data/tag/valid/dirty/LRU array with invalidate walk
module dcache_sram_assoc #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int SETS        = 16,
  parameter int WAYS        = 2,
  parameter int TAG_W       = 24,
  localparam int IDX_W      = $clog2(SETS),
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int BLK_W      = WORD_W * BLOCK_WORDS
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [IDX_W-1:0]       req_index,
  input  logic [TAG_W-1:0]       req_tag,
  output logic                   rsp_valid,
  output logic                   rsp_hit,
  output logic [WAY_W-1:0]       rsp_way,
  output logic [BLK_W-1:0]       rsp_data,
  output logic                   rsp_victim_valid,
  output logic                   rsp_victim_dirty,
  output logic [TAG_W-1:0]       rsp_victim_tag,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_index,
  input  logic [WAY_W-1:0]       wr_way,
  input  logic [TAG_W-1:0]       wr_tag,
  input  logic [BLOCK_WORDS-1:0] wr_mask,
  input  logic [BLK_W-1:0]       wr_data,
  input  logic                   wr_dirty,
  input  logic                   inv_start,
  output logic                   inv_busy,
  output logic                   inv_done
);

  typedef enum logic [1:0] {ST_WALK, ST_DONE, ST_IDLE} state_t;
  typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;

  logic [WORD_W-1:0] data_mem [SETS][WAYS][BLOCK_WORDS];
  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q  [SETS];
  logic [WAYS-1:0]   dirty_q  [SETS];
  ages_t             age_q    [SETS];

  logic             accept, wr_acc, hit;
  logic [WAY_W-1:0] hit_way, vic_way, sel_way;
  logic [BLK_W-1:0] sel_blk;
  ages_t            age_init, age_hit, age_wr_base, age_wr;

  // Touched way becomes youngest; ways younger than its old age shift one older.
  function automatic ages_t touch(input ages_t a, input logic [WAY_W-1:0] w);
    ages_t n;
    n = a;
    for (int i = 0; i < WAYS; i++) begin
      if (WAY_W'(i) == w) n[i] = '0;
      else if (a[i] < a[w]) n[i] = a[i] + 1'b1;
    end
    return n;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_WALK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    inv_busy  = 1'b0;
    inv_done  = 1'b0;
    case (state)
      ST_WALK: begin
        inv_busy = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == IDX_W'(SETS - 1)) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end
      end
      ST_DONE: begin
        inv_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready = 1'b1;
        if (inv_start) begin
          state_nxt = ST_WALK;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ST_WALK;
    endcase
  end

  assign accept = req_valid && req_ready;
  assign wr_acc = wr_en && req_ready;

  // Lowest matching way wins; victim is lowest invalid way, else the oldest.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_way = '0;
    sel_blk = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid_q[req_index][i] && (tag_mem[req_index][i] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
    end
    for (int i = 0; i < WAYS; i++)
      if (age_q[req_index][i] == WAY_W'(WAYS - 1)) vic_way = WAY_W'(i);
    for (int i = WAYS - 1; i >= 0; i--)
      if (!valid_q[req_index][i]) vic_way = WAY_W'(i);
    sel_way = hit ? hit_way : vic_way;
    for (int w = 0; w < BLOCK_WORDS; w++)
      sel_blk[w*WORD_W +: WORD_W] = data_mem[req_index][sel_way][w];
  end

  // A hit and a write in the same set chain: the write's touch sees the hit's result.
  always_comb begin
    age_init = '0;
    for (int i = 0; i < WAYS; i++) age_init[i] = WAY_W'(i);
    age_hit     = touch(age_q[req_index], hit_way);
    age_wr_base = (accept && hit && (wr_index == req_index)) ? age_hit : age_q[wr_index];
    age_wr      = touch(age_wr_base, wr_way);
  end

  always_ff @(posedge clock) begin
    if (state == ST_WALK) begin
      valid_q[cnt] <= '0;
      dirty_q[cnt] <= '0;
      age_q[cnt]   <= age_init;
    end else begin
      if (accept && hit) age_q[req_index] <= age_hit;
      if (wr_acc) begin
        for (int w = 0; w < BLOCK_WORDS; w++)
          if (wr_mask[w]) data_mem[wr_index][wr_way][w] <= wr_data[w*WORD_W +: WORD_W];
        tag_mem[wr_index][wr_way] <= wr_tag;
        valid_q[wr_index][wr_way] <= 1'b1;
        dirty_q[wr_index][wr_way] <= (&wr_mask) ? wr_dirty
                                                : (dirty_q[wr_index][wr_way] | wr_dirty);
        age_q[wr_index]           <= age_wr;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid        <= 1'b0;
      rsp_hit          <= 1'b0;
      rsp_way          <= '0;
      rsp_data         <= '0;
      rsp_victim_valid <= 1'b0;
      rsp_victim_dirty <= 1'b0;
      rsp_victim_tag   <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_hit          <= hit;
        rsp_way          <= sel_way;
        rsp_data         <= sel_blk;
        rsp_victim_valid <= valid_q[req_index][sel_way];
        rsp_victim_dirty <= dirty_q[req_index][sel_way];
        rsp_victim_tag   <= tag_mem[req_index][sel_way];
      end
    end
  end

endmodule

// File: tb/tb_dcache_sram_assoc.sv
// tb/tb_dcache_sram_assoc.sv - self-checking bench for dcache_sram_assoc
module tb_dcache_sram_assoc;
  localparam int SETS = 16;
  localparam int WAYS = 2;
  localparam int BW   = 4;

  localparam logic [127:0] D3   = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] DA   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] DB   = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  localparam logic [127:0] DST  = {32'h0, 32'h0, 32'hDEAD, 32'h0};
  localparam logic [127:0] DA2  = {32'hA3, 32'hA2, 32'hDEAD, 32'hA0};
  localparam logic [127:0] D7O  = {32'h70, 32'h71, 32'h72, 32'h73};
  localparam logic [127:0] D7N  = {32'h7A, 32'h7B, 32'h7C, 32'h7D};

  logic         clock, reset_n;
  logic         req_valid, req_ready;
  logic [3:0]   req_index;
  logic [23:0]  req_tag;
  logic         rsp_valid, rsp_hit;
  logic [0:0]   rsp_way;
  logic [127:0] rsp_data;
  logic         rsp_victim_valid, rsp_victim_dirty;
  logic [23:0]  rsp_victim_tag;
  logic         wr_en;
  logic [3:0]   wr_index;
  logic [0:0]   wr_way;
  logic [23:0]  wr_tag;
  logic [3:0]   wr_mask;
  logic [127:0] wr_data;
  logic         wr_dirty, inv_start, inv_busy, inv_done;

  dcache_sram_assoc #(.WORD_W(32), .BLOCK_WORDS(BW), .SETS(SETS), .WAYS(WAYS), .TAG_W(24)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_data(rsp_data),
    .rsp_victim_valid(rsp_victim_valid), .rsp_victim_dirty(rsp_victim_dirty),
    .rsp_victim_tag(rsp_victim_tag),
    .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .wr_tag(wr_tag), .wr_mask(wr_mask),
    .wr_data(wr_data), .wr_dirty(wr_dirty),
    .inv_start(inv_start), .inv_busy(inv_busy), .inv_done(inv_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic ck(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: recency kept as touch timestamps, oldest stamp = LRU.
  bit           m_valid [SETS][WAYS];
  bit           m_dirty [SETS][WAYS];
  bit           m_tk    [SETS][WAYS];
  logic [23:0]  m_tag   [SETS][WAYS];
  logic [31:0]  m_data  [SETS][WAYS][BW];
  bit           m_dk    [SETS][WAYS][BW];
  int           m_stamp [SETS][WAYS];
  int           m_tick = 0;
  int           m_walk_left = SETS;
  bit           m_done = 0, m_ready = 0;
  bit           e_valid, e_hit, e_vv, e_vd, e_tk, e_dk;
  int           e_way;
  logic [23:0]  e_vtag;
  logic [127:0] e_data;

  task automatic model_lookup();
    int s, way;
    s = int'(req_index);
    way = -1;
    e_hit = 0;
    for (int w = 0; w < WAYS; w++)
      if (way < 0 && m_valid[s][w] && m_tag[s][w] === req_tag) begin way = w; e_hit = 1; end
    if (way < 0)
      for (int w = 0; w < WAYS; w++) if (way < 0 && !m_valid[s][w]) way = w;
    if (way < 0) begin
      way = 0;
      for (int w = 1; w < WAYS; w++) if (m_stamp[s][w] < m_stamp[s][way]) way = w;
    end
    e_valid = 1; e_way = way;
    e_vv = m_valid[s][way]; e_vd = m_dirty[s][way];
    e_vtag = m_tag[s][way]; e_tk = m_tk[s][way];
    e_dk = 1;
    for (int k = 0; k < BW; k++) begin
      e_data[k*32 +: 32] = m_data[s][way][k];
      if (!m_dk[s][way][k]) e_dk = 0;
    end
    if (e_hit) begin m_tick++; m_stamp[s][way] = m_tick; end
  endtask

  task automatic model_write();
    int s, w;
    s = int'(wr_index);
    w = int'(wr_way);
    for (int k = 0; k < BW; k++)
      if (wr_mask[k]) begin m_data[s][w][k] = wr_data[k*32 +: 32]; m_dk[s][w][k] = 1; end
    m_tag[s][w] = wr_tag; m_tk[s][w] = 1;
    m_dirty[s][w] = (wr_mask == 4'hF) ? wr_dirty : (m_dirty[s][w] | wr_dirty);
    m_valid[s][w] = 1;
    m_tick++; m_stamp[s][w] = m_tick;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_walk_left = SETS; m_done = 0; m_ready = 0;
      e_valid = 0; e_hit = 0; e_way = 0; e_data = '0;
      e_vv = 0; e_vd = 0; e_vtag = '0; e_tk = 1; e_dk = 1;
    end else begin
      e_valid = 0;
      if (m_walk_left > 0) begin
        for (int w = 0; w < WAYS; w++) begin
          m_valid[SETS - m_walk_left][w] = 0;
          m_dirty[SETS - m_walk_left][w] = 0;
          m_stamp[SETS - m_walk_left][w] = -w;
        end
        m_walk_left--;
        if (m_walk_left == 0) m_done = 1;
      end else if (m_done) begin
        m_done = 0; m_ready = 1;
      end else begin
        if (req_valid) model_lookup();
        if (wr_en) model_write();
        if (inv_start) begin m_ready = 0; m_walk_left = SETS; end
      end
    end
  end

  always @(negedge clock) begin
    ck("req_ready", req_ready, m_ready);
    ck("inv_busy", inv_busy, m_walk_left > 0);
    ck("inv_done", inv_done, m_done);
    ck("rsp_valid", rsp_valid, e_valid);
    ck("rsp_hit", rsp_hit, e_hit);
    ck("rsp_way", rsp_way, e_way);
    ck("rsp_victim_valid", rsp_victim_valid, e_vv);
    ck("rsp_victim_dirty", rsp_victim_dirty, e_vd);
    if (e_tk) ck("rsp_victim_tag", rsp_victim_tag, e_vtag);
    if (e_dk) ck("rsp_data", rsp_data, e_data);
  end

  task automatic cyc(input bit rv, input int ri, input logic [23:0] rt,
                     input bit we, input int wi, input int ww, input logic [23:0] wt,
                     input logic [3:0] wm, input logic [127:0] wd, input bit wdy, input bit is);
    @(negedge clock);
    req_valid = rv; req_index = ri[3:0]; req_tag = rt;
    wr_en = we; wr_index = wi[3:0]; wr_way = ww[0:0]; wr_tag = wt;
    wr_mask = wm; wr_data = wd; wr_dirty = wdy; inv_start = is;
    @(posedge clock);
    #1;
  endtask

  task automatic nop();
    cyc(0, 0, 24'h0, 0, 0, 0, 24'h0, 4'h0, '0, 0, 0);
  endtask

  task automatic look(input int ri, input logic [23:0] rt);
    cyc(1, ri, rt, 0, 0, 0, 24'h0, 4'h0, '0, 0, 0);
  endtask

  task automatic wr(input int wi, input int ww, input logic [23:0] wt,
                    input logic [3:0] wm, input logic [127:0] wd, input bit wdy);
    cyc(0, 0, 24'h0, 1, wi, ww, wt, wm, wd, wdy, 0);
  endtask

  task automatic walk_len(input string name);
    int n;
    n = 0;
    while (inv_busy && n < 100) begin nop(); n++; end
    ck(name, n, 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    req_valid = 0; req_index = '0; req_tag = '0; wr_en = 0; wr_index = '0; wr_way = '0;
    wr_tag = '0; wr_mask = '0; wr_data = '0; wr_dirty = 0; inv_start = 0;
    reset_n = 1;
    #1 reset_n = 0;
    repeat (3) @(posedge clock);
    #1;
    ck("rst_busy", inv_busy, 1);
    ck("rst_ready", req_ready, 0);
    ck("rst_rsp_valid", rsp_valid, 0);
    ck("rst_rsp_data", rsp_data, 0);
    reset_n = 1;
    walk_len("walk_len_reset");
    ck("done_pulse", inv_done, 1);
    ck("done_not_ready", req_ready, 0);
    nop();
    ck("done_clear", inv_done, 0);
    ck("idle_ready", req_ready, 1);

    look(3, 24'h12);
    ck("cold_valid", rsp_valid, 1);
    ck("cold_hit", rsp_hit, 0);
    ck("cold_way", rsp_way, 0);
    ck("cold_vv", rsp_victim_valid, 0);

    wr(3, 0, 24'h12, 4'hF, D3, 0);
    look(3, 24'h12);
    ck("fill_hit", rsp_hit, 1);
    ck("fill_way", rsp_way, 0);
    ck("fill_data", rsp_data, D3);
    ck("fill_vd", rsp_victim_dirty, 0);

    wr(5, 0, 24'hA, 4'hF, DA, 0);
    wr(5, 1, 24'hB, 4'hF, DB, 0);
    look(5, 24'hA);
    ck("a_hit", rsp_hit, 1);
    look(5, 24'hC);
    ck("c_miss", rsp_hit, 0);
    ck("c_way", rsp_way, 1);
    ck("c_vtag", rsp_victim_tag, 24'hB);
    nop();
    ck("hold_valid", rsp_valid, 0);
    ck("hold_vtag", rsp_victim_tag, 24'hB);
    wr(5, 0, 24'hA, 4'b0010, DST, 1);
    look(5, 24'hA);
    ck("store_data", rsp_data, DA2);
    ck("store_dirty", rsp_victim_dirty, 1);
    wr(5, 1, 24'hB, 4'hF, DB, 0);
    look(5, 24'hC);
    ck("lru_way", rsp_way, 0);
    ck("lru_vtag", rsp_victim_tag, 24'hA);
    ck("lru_vd", rsp_victim_dirty, 1);

    wr(7, 0, 24'h77, 4'hF, D7O, 0);
    cyc(1, 7, 24'h77, 1, 7, 0, 24'h77, 4'hF, D7N, 0, 0);
    ck("rbw_old", rsp_data, D7O);
    look(7, 24'h77);
    ck("rbw_new", rsp_data, D7N);

    cyc(0, 0, 24'h0, 0, 0, 0, 24'h0, 4'h0, '0, 0, 1);
    ck("inv_busy", inv_busy, 1);
    n = 0;
    while (inv_busy && n < 100) begin
      cyc(1, 5, 24'hA, 1, 5, 1, 24'hB, 4'hF, '1, 1, n[0]);
      n++;
      ck("drop_valid", rsp_valid, 0);
    end
    ck("walk_len_cmd", n, 16);
    look(5, 24'hA);
    ck("done_drop", rsp_valid, 0);
    look(5, 24'hA);
    ck("post_valid", rsp_valid, 1);
    ck("post_hit", rsp_hit, 0);
    ck("post_vv", rsp_victim_valid, 0);
    look(3, 24'h12);
    ck("post3_hit", rsp_hit, 0);

    wr(5, 1, 24'hB, 4'hF, DB, 1);
    look(5, 24'hB);
    ck("pre_rst_way", rsp_way, 1);
    cyc(0, 0, 24'h0, 0, 0, 0, 24'h0, 4'h0, '0, 0, 1);
    repeat (7) nop();
    reset_n = 0;
    #1;
    ck("mid_rst_busy", inv_busy, 1);
    ck("mid_rst_way", rsp_way, 0);
    ck("mid_rst_data", rsp_data, 0);
    ck("mid_rst_vtag", rsp_victim_tag, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;
    walk_len("walk_len_rerun");
    nop();
    look(5, 24'hB);
    ck("rerun_miss", rsp_hit, 0);
    ck("rerun_vv", rsp_victim_valid, 0);
    wr(9, 1, 24'h99, 4'hF, DB, 0);
    look(9, 24'h99);
    ck("rerun_hit_way", rsp_way, 1);
    ck("rerun_hit_data", rsp_data, DB);
    nop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache_sram_assoc.md
Name: dcache_sram_assoc

Overview:
Parametrised N-way set-associative storage array for the write-back, write-allocate data cache. It holds the data, tag, valid, dirty and per-set LRU state. It performs a registered tag lookup with hit/victim selection and masked per-word writes. It also runs a set-walk invalidate engine that executes automatically after reset and on command. It sits between the data cache controller FSM and DRAM fill/writeback logic, replacing the single-way data-only SRAM.

Parameters:
WORD_W, 32, bits per word
BLOCK_WORDS, 4, words per cache block
SETS, 16, number of sets (power of 2); IDX_W = log2(SETS)
WAYS, 2, associativity (power of 2, 1..8); WAY_W = max(1, log2(WAYS))
TAG_W, 24, tag width

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  lookup request
req_ready  out  1  array accepts lookup/write (low while invalidate walk is busy)
req_index  in  IDX_W  lookup set
req_tag  in  TAG_W  lookup tag
rsp_valid  out  1  lookup result valid (one cycle after acceptance)
rsp_hit  out  1  tag matched a valid way
rsp_way  out  WAY_W  hit way, or victim way on miss
rsp_data  out  WORD_W*BLOCK_WORDS  block of rsp_way
rsp_victim_valid  out  1  victim way held valid line
rsp_victim_dirty  out  1  victim way dirty (writeback needed)
rsp_victim_tag  out  TAG_W  victim tag (writeback address)
wr_en  in  1  write strobe
wr_index  in  IDX_W  write set
wr_way  in  WAY_W  write way
wr_tag  in  TAG_W  tag stored with write
wr_mask  in  BLOCK_WORDS  per-word write enable
wr_data  in  WORD_W*BLOCK_WORDS  write block
wr_dirty  in  1  dirty value stored (0 = DRAM fill, 1 = store hit)
inv_start  in  1  pulse; start full invalidate
inv_busy  out  1  invalidate walk in progress
inv_done  out  1  one-cycle pulse at walk completion

Behaviour:
- One clock. Reset is asynchronous, active-low. Clock port `clock`; reset port `reset_n`.
- Reset values:
  - rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_victim_*=0, rsp_data=0.
  - inv_busy=1, inv_done=0, req_ready=0.
  - Walk counter=0.
- Data/tag arrays are not reset. Valid, dirty and LRU are cleared by the walk.
- FSM states:
  - WALK: entered on reset or on inv_start while IDLE. Each cycle clears valid/dirty/LRU of set cnt across all ways, then cnt++. After set SETS-1, go to DONE. Duration is exactly SETS cycles.
  - DONE: inv_done=1 for one cycle, inv_busy=0, then go to IDLE.
  - IDLE: req_ready=1.
- In WALK and DONE: req_ready=0. req_valid, wr_en and inv_start are ignored with no side effects. A lookup offered while not ready is dropped and produces no rsp_valid.
- reset_n asserted mid-walk restarts the walk from set 0 after release.
- Lookup is accepted when req_valid && req_ready at edge N. At edge N+1, rsp_valid=1 with results computed from array state sampled at edge N (read-before-write).
  - Hit: exactly one valid way whose tag == req_tag. rsp_way = that way; rsp_data = its block. Multiple matches are a controller bug: the lowest way wins.
  - Miss: victim = lowest-index invalid way; if all ways are valid, the LRU way. rsp_way and rsp_data show the victim.
  - rsp_victim_* reflect rsp_way, including on hit.
- rsp_valid stays 1 only while a new lookup is accepted each cycle. Outputs hold their last values otherwise.
- Write at edge N when wr_en && req_ready:
  - Masked words of (wr_index, wr_way) are updated.
  - tag <= wr_tag, valid <= 1, dirty <= wr_dirty.
  - A partial mask on a dirty line keeps dirty = dirty | wr_dirty.
  - wr_mask=0 still updates tag/valid/dirty.
- LRU: per set, WAYS age counters of WAY_W bits, all distinct after a walk (age = way index).
  - On a lookup hit or a write, the touched way's age becomes 0.
  - Ways younger than its old age increment; others are unchanged.
  - LRU way = age WAYS-1.
  - If a hit and a write touch the same set in one cycle, the write is applied last.
  - WAYS=1: rsp_way=0 always, no LRU storage.
- Write and lookup to the same set/way in the same cycle: the lookup returns old data/tag. The write lands, and a lookup at edge N+1 sees new data.
- inv_start while busy: ignored (no re-trigger).

Test Plan:
- Release reset, SETS=16 -> inv_busy=1 for 16 cycles, inv_done pulse on cycle 17, req_ready=1 from then; lookup idx 3 tag 0x12 -> rsp_hit=0, rsp_way=0, rsp_victim_valid=0.
- Fill write idx 3 way 0 tag 0x12 mask 1111 data {4,3,2,1} wr_dirty=0; lookup idx 3 tag 0x12 -> next cycle rsp_hit=1, rsp_way=0, data {4,3,2,1}, victim_dirty=0.
- WAYS=2: fill ways 0 and 1 of idx 5 (tags A, B), hit A, lookup tag C -> miss, rsp_way=1, victim_tag=B; store to way 0 mask 0010 wr_dirty=1 -> only word 1 changes, dirty=1.
- Same-cycle write idx 7 way 0 (new data X) and lookup idx 7 -> rsp shows old data; lookup next cycle -> X.
- inv_start mid-operation with dirty lines present -> req_ready=0 for 16 cycles, dropped requests give no rsp_valid; afterwards all lookups miss with victim_valid=0.
- Assert reset_n low at walk cycle 8 -> outputs return to reset values immediately; after release, the full 16-cycle walk reruns from set 0.
